// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer, its decoder and the bench.
// Holds the phase codes, the state width and the FSM state type.
package seq_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] PH_FETCH   = 3'd0;
    localparam logic [STATE_W-1:0] PH_DECODE  = 3'd1;
    localparam logic [STATE_W-1:0] PH_EXECUTE = 3'd2;
    localparam logic [STATE_W-1:0] PH_MEMORY  = 3'd3;
    localparam logic [STATE_W-1:0] PH_HALT    = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH   = PH_FETCH,
        ST_DECODE  = PH_DECODE,
        ST_EXECUTE = PH_EXECUTE,
        ST_MEMORY  = PH_MEMORY,
        ST_HALT    = PH_HALT
    } state_e;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: increments by one on each clock where en is
// high, wrapping from all-ones back to zero.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, clears the count
//   en    - count enable (one retire this cycle)
//   count - current count
module retire_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: steps each instruction through FETCH,
// DECODE, EXECUTE and an optional MEMORY phase, with variable execute length,
// memory wait-states, flush, halt/resume and a retired-instruction counter.
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   en                - global advance enable; everything holds when low
//   mem_ready         - memory handshake used in FETCH and MEMORY
//   exec_cycles       - extra EXECUTE cycles, sampled in DECODE
//   needs_mem         - instruction has a MEMORY phase, sampled in DECODE
//   halt_req          - go to HALT when the current instruction completes
//   flush             - abort the current instruction, restart at FETCH
//   resume            - leave HALT
//   state             - current phase code
//   fetch_en..mem_en  - per-phase enables, qualified by en
//   retire            - high on the completing cycle of an instruction
//   retired_count     - number of retired instructions (wraps)
//   halted            - sequencer is in HALT
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned EXEC_W     = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MEM_STAGE  = 1,
    parameter int unsigned FETCH_WAIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mem_ready,
    input  logic [EXEC_W-1:0]  exec_cycles,
    input  logic               needs_mem,
    input  logic               halt_req,
    input  logic               flush,
    input  logic               resume,
    output logic [STATE_W-1:0] state,
    output logic               fetch_en,
    output logic               decode_en,
    output logic               exec_en,
    output logic               mem_en,
    output logic               retire,
    output logic [CNT_W-1:0]   retired_count,
    output logic               halted
);

    localparam logic MEM_STAGE_EN  = (MEM_STAGE != 0);
    localparam logic FETCH_WAIT_EN = (FETCH_WAIT != 0);

    state_e              state_q, state_d;
    logic [EXEC_W-1:0]   exec_cnt_q, exec_cnt_d;
    logic                mem_flag_q, mem_flag_d;
    logic                complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            exec_cnt_q <= '0;
            mem_flag_q <= 1'b0;
        end else if (en) begin
            state_q    <= state_d;
            exec_cnt_q <= exec_cnt_d;
            mem_flag_q <= mem_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        exec_cnt_d = exec_cnt_q;
        mem_flag_d = mem_flag_q;
        complete   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (mem_ready || !FETCH_WAIT_EN) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                exec_cnt_d = exec_cycles;
                mem_flag_d = needs_mem & MEM_STAGE_EN;
                state_d    = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (exec_cnt_q != '0) begin
                    exec_cnt_d = exec_cnt_q - EXEC_W'(1);
                end else if (mem_flag_q) begin
                    state_d = ST_MEMORY;
                end else begin
                    complete = 1'b1;
                end
            end
            ST_MEMORY: begin
                if (mem_ready) begin
                    complete = 1'b1;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                // Unused codes fall back to a clean fetch.
                state_d = ST_FETCH;
            end
        endcase

        if (complete) begin
            state_d    = halt_req ? ST_HALT : ST_FETCH;
            mem_flag_d = 1'b0;
        end

        // Flush wins over completion: the instruction is abandoned, not retired.
        if (flush && (state_q != ST_HALT)) begin
            state_d    = ST_FETCH;
            exec_cnt_d = '0;
            mem_flag_d = 1'b0;
            complete   = 1'b0;
        end
    end

    // Gate with en so a retire pulse always coincides with a counted edge.
    assign retire = complete & en;

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (retire),
        .count (retired_count)
    );

    assign state     = state_q;
    assign fetch_en  = (state_q == ST_FETCH)   & en;
    assign decode_en = (state_q == ST_DECODE)  & en;
    assign exec_en   = (state_q == ST_EXECUTE) & en;
    assign mem_en    = (state_q == ST_MEMORY)  & en;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: two instances (full-featured with a 4-bit
// counter, and one without MEMORY phase or fetch wait) are driven by the same
// stimulus. A phase-plan reference model produces per-cycle expectations that
// are queued and checked by an independent monitor.
module tb_instr_sequencer;
    import seq_pkg::*;

    logic       clk;
    logic       t_rst;
    logic       t_en;
    logic       t_mr;
    logic [3:0] t_ec;
    logic       t_nm;
    logic       t_hr;
    logic       t_fl;
    logic       t_rs;

    logic [2:0]  st_a, st_b;
    logic        fe_a, de_a, ee_a, me_a, ret_a, hlt_a;
    logic        fe_b, de_b, ee_b, me_b, ret_b, hlt_b;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    int total = 0;
    int bad   = 0;

    instr_sequencer #(.EXEC_W(4), .CNT_W(4), .MEM_STAGE(1), .FETCH_WAIT(1)) dut_a (
        .clk(clk), .rst(t_rst), .en(t_en), .mem_ready(t_mr), .exec_cycles(t_ec),
        .needs_mem(t_nm), .halt_req(t_hr), .flush(t_fl), .resume(t_rs),
        .state(st_a), .fetch_en(fe_a), .decode_en(de_a), .exec_en(ee_a),
        .mem_en(me_a), .retire(ret_a), .retired_count(cnt_a), .halted(hlt_a)
    );

    instr_sequencer #(.EXEC_W(4), .CNT_W(16), .MEM_STAGE(0), .FETCH_WAIT(0)) dut_b (
        .clk(clk), .rst(t_rst), .en(t_en), .mem_ready(t_mr), .exec_cycles(t_ec),
        .needs_mem(t_nm), .halt_req(t_hr), .flush(t_fl), .resume(t_rs),
        .state(st_b), .fetch_en(fe_b), .decode_en(de_b), .exec_en(ee_b),
        .mem_en(me_b), .retire(ret_b), .retired_count(cnt_b), .halted(hlt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        en_s;
        logic [2:0]  st_a;
        logic        ret_a;
        logic [3:0]  cnt_a;
        logic [2:0]  st_b;
        logic        ret_b;
        logic [15:0] cnt_b;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the current phase plus a list of phases still to run
    // for the in-flight instruction. DECODE lays out the whole plan at once.
    int m_phase[2];
    int m_count[2];
    int plan[2][$];

    task automatic model_step(input int i, input bit fw, input bit ms, input int cmod,
                              output logic [2:0] st, output logic ret, output int cnt);
        int  nxt;
        bit  done;
        ret = 1'b0;
        if (t_rst) begin
            m_phase[i] = int'(PH_FETCH);
            m_count[i] = 0;
            plan[i].delete();
        end
        st  = 3'(m_phase[i]);
        cnt = m_count[i];
        if (t_rst || !t_en) return;
        nxt  = m_phase[i];
        done = 1'b0;
        if (t_fl && m_phase[i] != int'(PH_HALT)) begin
            plan[i].delete();
            nxt = int'(PH_FETCH);
        end else begin
            if (m_phase[i] == int'(PH_FETCH)) begin
                if (t_mr || !fw) nxt = int'(PH_DECODE);
            end else if (m_phase[i] == int'(PH_DECODE)) begin
                plan[i].delete();
                for (int k = 0; k <= int'(t_ec); k++) plan[i].push_back(int'(PH_EXECUTE));
                if (t_nm && ms) plan[i].push_back(int'(PH_MEMORY));
                nxt = plan[i].pop_front();
            end else if (m_phase[i] == int'(PH_EXECUTE)) begin
                done = 1'b1;
            end else if (m_phase[i] == int'(PH_MEMORY)) begin
                done = t_mr;
            end else if (m_phase[i] == int'(PH_HALT)) begin
                if (t_rs) nxt = int'(PH_FETCH);
            end else begin
                nxt = int'(PH_FETCH);
            end
            if (done) begin
                if (plan[i].size() == 0) begin
                    ret = 1'b1;
                    nxt = t_hr ? int'(PH_HALT) : int'(PH_FETCH);
                    m_count[i] = (m_count[i] + 1) % cmod;
                end else begin
                    nxt = plan[i].pop_front();
                end
            end
        end
        m_phase[i] = nxt;
    endtask

    // One stimulus cycle: inputs are already set; queue the expectation and
    // advance to the next falling edge.
    task automatic step();
        exp_t        e;
        logic [2:0]  s;
        logic        r;
        int          c;
        e.en_s = t_en;
        model_step(0, 1'b1, 1'b1, 16, s, r, c);
        e.st_a = s; e.ret_a = r; e.cnt_a = c[3:0];
        model_step(1, 1'b0, 1'b0, 65536, s, r, c);
        e.st_b = s; e.ret_b = r; e.cnt_b = c[15:0];
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_until_a(input int ph);
        for (int k = 0; k < 40 && m_phase[0] != ph; k++) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [4:0] phase_vec(input logic e, input logic [2:0] s);
        return {e && s == PH_FETCH, e && s == PH_DECODE, e && s == PH_EXECUTE,
                e && s == PH_MEMORY, s == PH_HALT};
    endfunction

    // Monitor: samples 2 time units after each falling edge, well away from
    // the rising edge, and checks against the oldest queued expectation.
    int n_retire = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("state_a",  32'(st_a),  32'(e.st_a));
                chk("retire_a", 32'(ret_a), 32'(e.ret_a));
                chk("count_a",  32'(cnt_a), 32'(e.cnt_a));
                chk("phase_a",  32'({fe_a, de_a, ee_a, me_a, hlt_a}), 32'(phase_vec(e.en_s, e.st_a)));
                chk("state_b",  32'(st_b),  32'(e.st_b));
                chk("retire_b", 32'(ret_b), 32'(e.ret_b));
                chk("count_b",  32'(cnt_b), 32'(e.cnt_b));
                chk("phase_b",  32'({fe_b, de_b, ee_b, me_b, hlt_b}), 32'(phase_vec(e.en_s, e.st_b)));
                if (e.ret_a) begin
                    n_retire++;
                    $display("retire A #%0d: count %0d at t=%0t", n_retire, e.cnt_a, $time);
                end
            end
        end
    end

    task automatic set_in(input bit e, input bit mr, input int ec, input bit nm,
                          input bit hr, input bit fl, input bit rs);
        t_en = e; t_mr = mr; t_ec = 4'(ec); t_nm = nm; t_hr = hr; t_fl = fl; t_rs = rs;
    endtask

    initial begin
        t_rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        m_phase[0] = 0; m_phase[1] = 0; m_count[0] = 0; m_count[1] = 0;
        @(negedge clk);
        // Reset held for two cycles, with en both low and high.
        step();
        t_en = 1'b1;
        step();
        t_rst = 1'b0;

        // Minimum-length instructions back to back.
        set_in(1, 1, 0, 0, 0, 0, 0);
        repeat (6) step();

        // Extended execute.
        set_in(1, 1, 3, 0, 0, 0, 0);
        repeat (6) step();

        // Memory phase with two wait states.
        set_in(1, 1, 0, 1, 0, 0, 0);
        run_until_a(int'(PH_MEMORY));
        t_mr = 1'b0;
        repeat (2) step();
        t_mr = 1'b1;
        step();

        // Flush in the second EXECUTE cycle of a long instruction.
        set_in(1, 1, 5, 0, 0, 0, 0);
        run_until_a(int'(PH_EXECUTE));
        step();
        t_fl = 1'b1;
        step();
        t_fl = 1'b0;
        repeat (3) step();

        // Flush coincident with completion.
        set_in(1, 1, 0, 0, 0, 0, 0);
        run_until_a(int'(PH_FETCH));
        run_until_a(int'(PH_EXECUTE));
        t_fl = 1'b1;
        step();
        t_fl = 1'b0;

        // Halt on completion, flush ignored while halted, then resume.
        set_in(1, 1, 0, 0, 1, 0, 0);
        repeat (4) step();
        t_hr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            t_fl = (k == 4);
            step();
        end
        t_fl = 1'b0;
        t_rs = 1'b1;
        step();
        t_rs = 1'b0;
        repeat (3) step();

        // Enable dropped mid-EXECUTE.
        set_in(1, 1, 2, 0, 0, 0, 0);
        run_until_a(int'(PH_FETCH));
        run_until_a(int'(PH_EXECUTE));
        t_en = 1'b0;
        repeat (4) step();
        t_en = 1'b1;
        repeat (6) step();

        // Randomized traffic, with one asynchronous reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            t_rst = (n == 1500);
            t_en  = ($urandom_range(0, 9) != 0);
            t_mr  = ($urandom_range(0, 3) != 0);
            t_ec  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            t_nm  = $urandom_range(0, 1) == 1;
            t_hr  = ($urandom_range(0, 7) == 0);
            t_fl  = ($urandom_range(0, 19) == 0);
            t_rs  = ($urandom_range(0, 3) == 0);
            step();
        end
        t_rst = 1'b0;
        set_in(1, 1, 0, 0, 0, 0, 1);
        repeat (20) step();

        #4;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
